fp_round_unit: RTL and testbench
================================

Name: fp_round_unit

Overview:
- Rounding stage directly downstream of the FP arithmetic units (mul/add/div).
- Takes a normalized float_t, the guard/round/sticky bits and the upstream exception flags, and applies the RISC-V rounding mode.
- Handles mantissa carry-out, overflow saturation by rounding mode, and special-value pass-through.
- Delivers the final IEEE-754 single-precision result and flags to writeback/FCSR.

Parameters:
- LATENCY_CHECK, 1, when 1 adds a simulation-only assertion that valid_o follows capture by exactly 3 enabled cycles.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- clk_en_i  in  1  clock enable; when 0, state and registers are frozen
- valid_i  in  1  input data valid, sampled only in IDLE
- to_round_i  in  float_t(32)  normalized unrounded result
- grs_i  in  3  {guard, round, sticky} bits below mantissa LSB
- rm_i  in  3  round_mode_e: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
- overflow_i / underflow_i / invalid_i  in  1 each  upstream exception flags
- result_o  out  float_t(32)  rounded result
- valid_o  out  1  result valid, one-cycle pulse
- fu_state_o  out  fu_state_e  FREE in IDLE, BUSY otherwise
- overflow_o, underflow_o, inexact_o, invalid_op_o  out  1 each  exception flags

Behaviour:
- Reset (asynchronous, rst_n_i=0):
  - state=IDLE; result_o=0; all flags=0; valid_o=0; fu_state_o=FREE.
  - Reset mid-operation aborts the operation; no valid_o pulse is produced.
- FSM states: IDLE, ROUND, NORMALIZE, VALID. All transitions are gated by clk_en_i.
  - IDLE: if valid_i=1, capture to_round_i, grs_i, rm_i and flags, then go to ROUND; otherwise stay.
  - ROUND: compute the increment and the 24-bit sum {1,mantissa}+inc with carry-out; go to NORMALIZE.
  - NORMALIZE: on carry-out, shift the mantissa right by 1 and increment the exponent. Resolve overflow and specials. Register the outputs. Go to VALID.
  - VALID: valid_o=1 for one cycle; go to IDLE.
- Latency: 3 enabled cycles from the capture edge to the valid_o cycle. Throughput: 1 result per 4 cycles.
- valid_i outside IDLE is ignored; upstream must wait for fu_state_o=FREE.
- result_o and flags hold their value until the next NORMALIZE.
- Increment rule, with G/R/S = grs_i and L = mantissa LSB:
  - RNE: G&(R|S|L)
  - RTZ: 0
  - RDN: sign&(G|R|S)
  - RUP: !sign&(G|R|S)
  - RMM: G
- inexact_o = G|R|S for finite results.
- Exponent rules:
  - Exponent 254 with carry-out, or overflow_i=1, gives overflow_o=1 and inexact_o=1.
  - On overflow, RNE/RMM produce ±INF.
  - On overflow, RTZ produces ±MAX_FINITE (0x7F7FFFFF with sign).
  - On overflow, RDN produces +MAX_FINITE or -INF; RUP produces +INF or -MAX_FINITE.
  - Exponent 255 input (INF/NaN) passes through unrounded with inexact_o=0.
  - A NaN input is canonicalized to CANO_NAN.
- invalid_i=1 forces result=CANO_NAN, invalid_op_o=1, other flags 0.
- Illegal rm (101, 110, 111) gives result=CANO_NAN and invalid_op_o=1.
- underflow_o = underflow_i | (exponent==0 & inexact).
- Zero input (exponent 0, mantissa 0, grs 0) gives signed zero with no flags.

Optional Feature:
- FP_ROUND_FTZ_EN defined: any result with exponent 0 is flushed to signed zero, with underflow_o=1 and inexact_o=1 if the mantissa or G/R/S was nonzero.
- Undefined: subnormal results are rounded like normals, without the hidden bit; a carry into bit 23 sets exponent=1.

Decomposition:
- Add to Modules_pkg: round_mode_e enum, MAX_FINITE constant, fsm state enum fp_round_state_e.
- Reuse float_t, fu_state_e, CANO_NAN, P_INFTY, N_INFTY.
- Sub-module fp_round_decider: combinational {sign, L, G, R, S, rm} -> {inc, inexact, illegal_rm}.

Test Plan:
- to_round_i=0x3F800000, grs=100, rm=RNE → result 0x3F800000 (tie, even L=0), inexact_o=1, valid_o exactly 3 cycles after capture.
- to_round_i=0x3F800001, grs=100, rm=RNE → 0x3F800002; same input with rm=RTZ → 0x3F800001; both inexact_o=1.
- to_round_i=0x3FFFFFFF, grs=110, rm=RUP → carry-out gives 0x40000000.
- to_round_i=0x7F7FFFFF, grs=100, rm=RNE → 0x7F800000 with overflow_o=1; same input with rm=RTZ → 0x7F7FFFFF, overflow_o=1.
- to_round_i=0xFF7FFFFF, grs=111, rm=RDN → 0xFF800000; with rm=RUP → 0xFF7FFFFF.
- Reset asserted during NORMALIZE → outputs 0 immediately and no valid_o pulse.
- rm=101 → CANO_NAN with invalid_op_o=1.
- valid_i pulsed during BUSY → ignored.

Source files
------------

// File: rtl/fp_round_unit_pkg.sv
// rtl/fp_round_unit_pkg.sv - shared float types, rounding-mode/FSM enums and special-value constants.
package fp_round_unit_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float_t;

  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } fu_state_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } round_mode_e;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ROUND     = 2'd1,
    S_NORMALIZE = 2'd2,
    S_VALID     = 2'd3
  } fp_round_state_e;

  localparam float_t CANO_NAN   = 32'h7FC0_0000;
  localparam float_t P_INFTY    = 32'h7F80_0000;
  localparam float_t N_INFTY    = 32'hFF80_0000;
  localparam float_t MAX_FINITE = 32'h7F7F_FFFF;

  // Saturation target on overflow: either signed infinity or signed largest finite.
  function automatic float_t ovf_result(input logic sign, input logic [2:0] rm);
    logic to_inf;
    to_inf = (rm == RNE) || (rm == RMM) || ((rm == RDN) && sign) || ((rm == RUP) && !sign);
    if (to_inf) begin
      return sign ? N_INFTY : P_INFTY;
    end
    return '{sign: sign, exponent: MAX_FINITE.exponent, mantissa: MAX_FINITE.mantissa};
  endfunction

endpackage

// File: rtl/fp_round_unit_if.sv
// rtl/fp_round_unit_if.sv - operand/result bundle between the FP arithmetic units and the rounding stage.
interface fp_round_unit_if;
  import fp_round_unit_pkg::*;

  logic        valid_i;
  float_t      to_round_i;
  logic [2:0]  grs_i;
  logic [2:0]  rm_i;
  logic        overflow_i;
  logic        underflow_i;
  logic        invalid_i;

  float_t      result_o;
  logic        valid_o;
  fu_state_e   fu_state_o;
  logic        overflow_o;
  logic        underflow_o;
  logic        inexact_o;
  logic        invalid_op_o;

  modport slave (
    input  valid_i, to_round_i, grs_i, rm_i, overflow_i, underflow_i, invalid_i,
    output result_o, valid_o, fu_state_o, overflow_o, underflow_o, inexact_o, invalid_op_o
  );

  modport master (
    output valid_i, to_round_i, grs_i, rm_i, overflow_i, underflow_i, invalid_i,
    input  result_o, valid_o, fu_state_o, overflow_o, underflow_o, inexact_o, invalid_op_o
  );
endinterface

// File: rtl/fp_round_decider.sv
// rtl/fp_round_decider.sv - combinational increment/inexact/illegal-mode decision from sign, LSB, G/R/S and rm.
module fp_round_decider
  import fp_round_unit_pkg::*;
(
  input  logic       i_sign,
  input  logic       i_lsb,
  input  logic [2:0] i_grs,
  input  logic [2:0] i_rm,
  output logic       o_inc,
  output logic       o_inexact,
  output logic       o_illegal_rm
);

  logic w_g, w_r, w_s, w_any;

  assign w_g   = i_grs[2];
  assign w_r   = i_grs[1];
  assign w_s   = i_grs[0];
  assign w_any = w_g | w_r | w_s;

  always_comb begin
    o_inc        = 1'b0;
    o_illegal_rm = 1'b0;
    o_inexact    = w_any;
    case (i_rm)
      RNE:     o_inc = w_g & (w_r | w_s | i_lsb);
      RTZ:     o_inc = 1'b0;
      RDN:     o_inc = i_sign & w_any;
      RUP:     o_inc = !i_sign & w_any;
      RMM:     o_inc = w_g;
      default: o_illegal_rm = 1'b1;
    endcase
  end

endmodule

// File: rtl/fp_round_unit.sv
// rtl/fp_round_unit.sv - IEEE-754 single rounding stage: capture, round, normalize/saturate, one-cycle valid.
// Optional macro FP_ROUND_FTZ_EN flushes exponent-0 results to signed zero.
module fp_round_unit
  import fp_round_unit_pkg::*;
#(
  parameter int unsigned LATENCY_CHECK = 1
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           clk_en_i,
  fp_round_unit_if.slave io_bus
);

  fp_round_state_e r_state, w_next;

  float_t      r_in;
  logic [2:0]  r_grs, r_rm;
  logic        r_ovf_in, r_unf_in, r_inv_in;
  logic [24:0] r_sum;
  logic        r_inexact, r_illegal;
  float_t      r_result;
  logic        r_ovf, r_unf, r_inx, r_invop;

  logic        w_capture, w_inc, w_inexact, w_illegal_rm, w_ovf_hit;
  float_t      w_res;
  logic [7:0]  w_exp;
  logic [22:0] w_man;
  logic        w_ovf_f, w_unf_f, w_inx_f, w_inv_f;

  assign w_capture = (r_state == S_IDLE) && io_bus.valid_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else if (clk_en_i) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (io_bus.valid_i) w_next = S_ROUND;
      S_ROUND:     w_next = S_NORMALIZE;
      S_NORMALIZE: w_next = S_VALID;
      S_VALID:     w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  fp_round_decider u_decider (
    .i_sign       (r_in.sign),
    .i_lsb        (r_in.mantissa[0]),
    .i_grs        (r_grs),
    .i_rm         (r_rm),
    .o_inc        (w_inc),
    .o_inexact    (w_inexact),
    .o_illegal_rm (w_illegal_rm)
  );

  // Overflow is judged against the round-to-nearest magnitude, so directed modes that
  // saturate to MAX_FINITE still raise the flag.
  assign w_ovf_hit = r_ovf_in |
                     ((r_in.exponent == 8'd254) & (r_sum[24] | ((&r_in.mantissa) & r_grs[2])));

  always_comb begin
    w_res   = r_in;
    w_ovf_f = 1'b0;
    w_unf_f = 1'b0;
    w_inx_f = 1'b0;
    w_inv_f = 1'b0;
    w_exp   = r_in.exponent;
    w_man   = r_sum[22:0];
    if (r_sum[24]) begin
      w_exp = r_in.exponent + 8'd1;
      w_man = r_sum[23:1];
    end else if ((r_in.exponent == 8'd0) && r_sum[23]) begin
      w_exp = 8'd1;
    end

    if (r_inv_in || r_illegal) begin
      w_res   = CANO_NAN;
      w_inv_f = 1'b1;
    end else if (&r_in.exponent) begin
      w_res = (|r_in.mantissa) ? CANO_NAN : r_in;
    end else if (w_ovf_hit) begin
      w_res   = ovf_result(r_in.sign, r_rm);
      w_ovf_f = 1'b1;
      w_inx_f = 1'b1;
      w_unf_f = r_unf_in;
    end else begin
`ifdef FP_ROUND_FTZ_EN
      if (w_exp == 8'd0) begin
        w_res   = '{sign: r_in.sign, exponent: 8'd0, mantissa: 23'd0};
        w_inx_f = (|r_in.mantissa) | (|r_grs);
        w_unf_f = r_unf_in | (|r_in.mantissa) | (|r_grs);
      end else begin
        w_res   = '{sign: r_in.sign, exponent: w_exp, mantissa: w_man};
        w_inx_f = r_inexact;
        w_unf_f = r_unf_in;
      end
`else
      w_res   = '{sign: r_in.sign, exponent: w_exp, mantissa: w_man};
      w_inx_f = r_inexact;
      w_unf_f = r_unf_in | ((w_exp == 8'd0) & r_inexact);
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_in      <= '0;
      r_grs     <= '0;
      r_rm      <= '0;
      r_ovf_in  <= 1'b0;
      r_unf_in  <= 1'b0;
      r_inv_in  <= 1'b0;
      r_sum     <= '0;
      r_inexact <= 1'b0;
      r_illegal <= 1'b0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_inx     <= 1'b0;
      r_invop   <= 1'b0;
    end else if (clk_en_i) begin
      if (w_capture) begin
        r_in     <= io_bus.to_round_i;
        r_grs    <= io_bus.grs_i;
        r_rm     <= io_bus.rm_i;
        r_ovf_in <= io_bus.overflow_i;
        r_unf_in <= io_bus.underflow_i;
        r_inv_in <= io_bus.invalid_i;
      end
      if (r_state == S_ROUND) begin
        // Subnormals carry no hidden bit; a carry into bit 23 then promotes to exponent 1.
        r_sum     <= {1'b0, |r_in.exponent, r_in.mantissa} + 25'(w_inc);
        r_inexact <= w_inexact;
        r_illegal <= w_illegal_rm;
      end
      if (r_state == S_NORMALIZE) begin
        r_result <= w_res;
        r_ovf    <= w_ovf_f;
        r_unf    <= w_unf_f;
        r_inx    <= w_inx_f;
        r_invop  <= w_inv_f;
      end
    end
  end

  assign io_bus.result_o     = r_result;
  assign io_bus.valid_o      = (r_state == S_VALID);
  assign io_bus.fu_state_o   = (r_state == S_IDLE) ? FREE : BUSY;
  assign io_bus.overflow_o   = r_ovf;
  assign io_bus.underflow_o  = r_unf;
  assign io_bus.inexact_o    = r_inx;
  assign io_bus.invalid_op_o = r_invop;

  generate
    if (LATENCY_CHECK != 0) begin : g_latency_check
      logic [1:0] r_lat_cnt;
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          r_lat_cnt <= '0;
        end else if (clk_en_i) begin
          if (w_capture) begin
            r_lat_cnt <= 2'd1;
          end else if (r_lat_cnt != 2'd3) begin
            r_lat_cnt <= r_lat_cnt + 2'd1;
          end
        end
      end
      a_latency: assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                  (r_state == S_VALID) |-> (r_lat_cnt == 2'd3));
    end
  endgenerate

endmodule

// File: tb/tb_fp_round_unit.sv
// tb/tb_fp_round_unit.sv - scoreboard bench for fp_round_unit: directed corners plus randomized operands.
module tb_fp_round_unit;
  import fp_round_unit_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        inx;
    logic        inv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clk_en;
  bit   rand_en = 1'b0;

  exp_t exp_q[$];
  int   cap_q[$];
  int   en_cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fp_round_unit_if bus ();

  fp_round_unit #(.LATENCY_CHECK(1)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .clk_en_i (clk_en),
    .io_bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: value-level rounding from the mode rules, independent of the RTL datapath.
  function automatic exp_t model(input logic [31:0] f, input logic [2:0] grs, input logic [2:0] rm,
                                 input logic ovi, input logic uni, input logic inv);
    exp_t r;
    int   e, m, sig, g;
    bit   s, up, big, to_inf;
    r = '{res: 32'h0, ovf: 1'b0, unf: 1'b0, inx: 1'b0, inv: 1'b0};
    s = f[31];
    e = int'(f[30:23]);
    m = int'(f[22:0]);
    g = int'(grs);
    if (inv || rm > 3'd4) begin
      r.res = 32'h7FC0_0000;
      r.inv = 1'b1;
      return r;
    end
    if (e == 255) begin
      r.res = (m != 0) ? 32'h7FC0_0000 : f;
      return r;
    end
    case (rm)
      3'd0:    up = (g > 4) || (g == 4 && (m % 2) == 1);
      3'd1:    up = 1'b0;
      3'd2:    up = s && (g != 0);
      3'd3:    up = !s && (g != 0);
      default: up = (g >= 4);
    endcase
    sig = ((e != 0) ? (1 << 23) : 0) + m + int'(up);
    big = (e == 254) && ((sig >= (1 << 24)) || ((((1 << 23) + m) * 8 + g) >= (((1 << 24) - 1) * 8 + 4)));
    if (big || ovi) begin
      r.ovf  = 1'b1;
      r.inx  = 1'b1;
      r.unf  = uni;
      to_inf = (rm == 3'd0) || (rm == 3'd4) || (rm == 3'd2 && s) || (rm == 3'd3 && !s);
      r.res  = to_inf ? {s, 8'hFF, 23'h0} : {s, 31'h7F7F_FFFF};
      return r;
    end
    if (e == 0) begin
      if (sig >= (1 << 23)) begin
        e = 1;
        m = sig - (1 << 23);
      end else begin
        m = sig;
      end
    end else if (sig >= (1 << 24)) begin
      e = e + 1;
      m = (sig >> 1) - (1 << 23);
    end else begin
      m = sig - (1 << 23);
    end
    r.inx = (g != 0);
    r.unf = uni || (e == 0 && r.inx);
    r.res = {s, e[7:0], m[22:0]};
    return r;
  endfunction

  initial begin
    clk_en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      clk_en = rand_en ? ($urandom_range(0, 9) != 0) : 1'b1;
    end
  end

  // Monitor: records capture cycles and checks each valid_o pulse against the scoreboard.
  initial begin
    exp_t e;
    int   c;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (bus.valid_o && clk_en) begin
          if (exp_q.size() == 0 || cap_q.size() == 0) begin
            chk("spurious_valid", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            c = cap_q.pop_front();
            chk("result", 64'(bus.result_o), 64'(e.res));
            chk("flags", 64'({bus.overflow_o, bus.underflow_o, bus.inexact_o, bus.invalid_op_o}),
                64'({e.ovf, e.unf, e.inx, e.inv}));
            chk("latency", 64'(en_cnt), 64'(c + 3));
          end
        end
        if (bus.fu_state_o == FREE && bus.valid_i && clk_en) cap_q.push_back(en_cnt);
        if (clk_en) en_cnt++;
      end
    end
  end

  task automatic issue(input logic [31:0] f, input logic [2:0] grs, input logic [2:0] rm,
                       input logic ovi, input logic uni, input logic inv, input bit hold_busy);
    int guard;
    guard = 0;
    @(negedge clk);
    while (bus.fu_state_o != FREE) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        chk("timeout_free", 64'd1, 64'd0);
        return;
      end
    end
    @(posedge clk);
    #2;
    bus.to_round_i  = f;
    bus.grs_i       = grs;
    bus.rm_i        = rm;
    bus.overflow_i  = ovi;
    bus.underflow_i = uni;
    bus.invalid_i   = inv;
    bus.valid_i     = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!clk_en) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        chk("timeout_capture", 64'd1, 64'd0);
        bus.valid_i = 1'b0;
        return;
      end
    end
    exp_q.push_back(model(f, grs, rm, ovi, uni, inv));
    @(posedge clk);
    #2;
    if (hold_busy) begin
      bus.to_round_i = 32'h4049_0FDB;
      bus.rm_i       = 3'd3;
      bus.grs_i      = 3'b111;
      @(posedge clk);
      #2;
    end
    bus.valid_i = 1'b0;
  endtask

  initial begin
    logic [31:0] f;
    logic [2:0]  grs, rm;
    logic        ovi, uni, inv;
    int          cat, w;

    rst_n           = 1'b0;
    bus.valid_i     = 1'b0;
    bus.to_round_i  = '0;
    bus.grs_i       = '0;
    bus.rm_i        = '0;
    bus.overflow_i  = 1'b0;
    bus.underflow_i = 1'b0;
    bus.invalid_i   = 1'b0;
    #2;
    chk("reset_outputs", 64'({bus.result_o, bus.valid_o, bus.fu_state_o, bus.overflow_o,
                             bus.underflow_o, bus.inexact_o, bus.invalid_op_o}), 64'({32'h0, 1'b0, FREE, 4'h0}));
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    issue(32'h3F80_0000, 3'b100, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(32'h3F80_0001, 3'b100, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(32'h3F80_0001, 3'b100, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(32'h3FFF_FFFF, 3'b110, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(32'h7F7F_FFFF, 3'b100, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(32'h7F7F_FFFF, 3'b100, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(32'hFF7F_FFFF, 3'b111, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(32'hFF7F_FFFF, 3'b111, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(32'h3F80_0000, 3'b000, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(32'h8000_0000, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(32'h007F_FFFF, 3'b100, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(32'h7FA0_0001, 3'b101, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(32'h4120_0000, 3'b011, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(32'h4120_0001, 3'b001, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1);

    // Abort from NORMALIZE: capture, one more edge into NORMALIZE, then reset.
    issue(32'h4000_0001, 3'b111, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", 64'({bus.result_o, bus.valid_o, bus.fu_state_o, bus.overflow_o,
                             bus.underflow_o, bus.inexact_o, bus.invalid_op_o}), 64'({32'h0, 1'b0, FREE, 4'h0}));
    exp_q.delete();
    cap_q.delete();
    w = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.valid_o) w++;
    end
    chk("abort_no_valid", 64'(w), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    rand_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      cat = $urandom_range(0, 9);
      f   = $urandom();
      grs = 3'($urandom_range(0, 7));
      rm  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      inv = ($urandom_range(0, 19) == 0);
      ovi = 1'b0;
      uni = 1'b0;
      case (cat)
        0: begin f[30:0] = '0; if ($urandom_range(0, 1) == 0) grs = 3'b000; end
        1: f[30:23] = 8'd0;
        2: f[30:0] = 31'h7F7F_FFFF;
        3: begin f[30:23] = 8'hFF; if ($urandom_range(0, 1) == 0) f[22:0] = '0; end
        4: f[30:23] = 8'd254;
        5: begin f[22:0] = '1; f[30:23] = 8'($urandom_range(1, 253)); end
        default: f[30:23] = 8'($urandom_range(1, 253));
      endcase
      if (cat != 3) begin
        ovi = ($urandom_range(0, 15) == 0);
        uni = ($urandom_range(0, 15) == 0);
      end
      issue(f, grs, rm, ovi, uni, inv, 1'b0);
    end

    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
